limn2600_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer sitting between the Limn2600 core and the single-ported `limn2600_SRAM`. It shares the SRAM between the instruction-fetch port (m0) and the load/store port (m1) using round-robin grant. It issues each access as a one-cycle chip-select pulse, waits for `rdy`, and returns data with a one-cycle acknowledge. It also rejects misaligned accesses and bounds the wait with a timeout.

---
 rtl/limn2600_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_limn2600_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/limn2600_mem_arbiter.sv
// Round-robin arbiter that shares the single-ported SRAM between fetch (m0) and load/store (m1).
// Each access is IDLE -> ISSUE (one-cycle cs) -> WAIT (for rdy, bounded) -> RESP (one-cycle ack).
module limn2600_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [31:0]           m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [31:0]           m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rdy,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t          state;
    logic            last_m1;
    logic            port_sel;
    logic [7:0]      wait_cnt;

    logic                  gnt_any;
    logic                  gnt_m1;
    logic                  gnt_we;
    logic [31:0]           gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;
    logic                  gnt_mis;

    // The last WAIT cycle is the one where the counter reaches TIMEOUT-1.
    function automatic logic timeout_hit(input logic [7:0] cnt);
        return cnt == TO_LAST;
    endfunction

    always_comb begin
        gnt_any   = m0_req | m1_req;
        gnt_m1    = m1_req & (~m0_req | ~last_m1);
        gnt_we    = gnt_m1 ? m1_we    : m0_we;
        gnt_addr  = gnt_m1 ? m1_addr  : m0_addr;
        gnt_wdata = gnt_m1 ? m1_wdata : m0_wdata;
        gnt_mis   = |gnt_addr[1:0];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_m1   <= 1'b1;
            port_sel  <= 1'b0;
            wait_cnt  <= 8'd0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= '0;
            m0_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_ack    <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        last_m1  <= gnt_m1;
                        port_sel <= gnt_m1;
                        if (gnt_mis) begin
                            // Misaligned: answer with an error without touching the SRAM.
                            state  <= RESP;
                            m0_ack <= ~gnt_m1;
                            m0_err <= ~gnt_m1;
                            m1_ack <= gnt_m1;
                            m1_err <= gnt_m1;
                        end else begin
                            state     <= ISSUE;
                            mem_cs    <= 1'b1;
                            mem_we    <= gnt_we;
                            mem_addr  <= gnt_addr;
                            mem_wdata <= gnt_wdata;
                        end
                    end
                end
                ISSUE: begin
                    mem_cs   <= 1'b0;
                    wait_cnt <= 8'd0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (mem_rdy) begin
                        state    <= RESP;
                        m0_ack   <= ~port_sel;
                        m1_ack   <= port_sel;
                        m0_rdata <= (port_sel || mem_we) ? '0 : mem_rdata;
                        m1_rdata <= (!port_sel || mem_we) ? '0 : mem_rdata;
                    end else if (timeout_hit(wait_cnt)) begin
                        state  <= RESP;
                        m0_ack <= ~port_sel;
                        m0_err <= ~port_sel;
                        m1_ack <= port_sel;
                        m1_err <= port_sel;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    m0_ack   <= 1'b0;
                    m0_err   <= 1'b0;
                    m0_rdata <= '0;
                    m1_ack   <= 1'b0;
                    m1_err   <= 1'b0;
                    m1_rdata <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_limn2600_mem_arbiter.sv
// Scoreboard bench for limn2600_mem_arbiter with a behavioural one-cycle-latency SRAM.
module tb_limn2600_mem_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0]   m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_cs, mem_we, busy;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rdy = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          rdy_en = 1'b1;
    logic [31:0]   sram [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          port;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    limn2600_mem_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .busy(busy)
    );

    // SRAM model: rdy and read data one cycle after cs, unless rdy_en is cleared.
    always @(posedge clk) begin
        mem_rdy <= 1'b0;
        if (mem_cs && rdy_en) begin
            mem_rdy <= 1'b1;
            if (mem_we) begin
                sram[mem_addr[9:2]] <= mem_wdata;
                mem_rdata <= '0;
            end else begin
                mem_rdata <= sram[mem_addr[9:2]];
            end
        end
    end

    // Every ack is matched against the oldest expected response.
    always @(negedge clk) begin
        if (m0_ack || m1_ack) begin
            logic [2*DW+3:0] obs, req;
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack m0_ack=%0b m1_ack=%0b required no ack", m0_ack, m1_ack);
            end else begin
                e = sb.pop_front();
                obs = {m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata};
                if (e.port)
                    req = {1'b0, 1'b0, {DW{1'b0}}, 1'b1, e.err, e.rdata};
                else
                    req = {1'b1, e.err, e.rdata, 1'b0, 1'b0, {DW{1'b0}}};
                if (obs !== req) begin
                    errors++;
                    $display("FAIL ack_response actual=%h required=%h", obs, req);
                end
            end
        end
    end

    task automatic wait_ack(input int budget, output int k_ack, output bit seen);
        seen = 1'b0;
        k_ack = -1;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                seen = 1'b1;
                k_ack = k;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_cs, mem_we, busy, m0_ack, m1_ack, m0_err, m1_err} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl actual=%b required=0000000",
                     {mem_cs, mem_we, busy, m0_ack, m1_ack, m0_err, m1_err});
        end
        checks++;
        if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%h wdata=%h r0=%h r1=%h required 0",
                     mem_addr, mem_wdata, m0_rdata, m1_rdata);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy actual=%b required=0", busy);
        end
    endtask

    task automatic test_single_read();
        sb.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (mem_cs !== (k == 1)) begin
                errors++;
                $display("FAIL read_cs cycle=%0d actual=%b required=%b", k, mem_cs, k == 1);
            end
            checks++;
            if (busy !== (k >= 1 && k <= 3)) begin
                errors++;
                $display("FAIL read_busy cycle=%0d actual=%b required=%b", k, busy, k >= 1 && k <= 3);
            end
            checks++;
            if (m0_ack !== (k == 3)) begin
                errors++;
                $display("FAIL read_ack cycle=%0d actual=%b required=%b", k, m0_ack, k == 3);
            end
            if (k == 1) begin
                checks++;
                if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL read_addr actual=%h/%b required=00000100/0", mem_addr, mem_we);
                end
            end
            if (k == 3) begin
                @(posedge clk); #1 m0_req = 1'b0;
            end
        end
    endtask

    task automatic test_write_read();
        int k;
        bit seen;
        sb.push_back('{1'b1, 1'b0, 32'h0});
        @(posedge clk); #1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h00F80010; m1_wdata = 32'h12345678;
        wait_ack(10, k, seen);
        checks++;
        if (!seen || k != 3) begin
            errors++;
            $display("FAIL write_ack_cycle actual=%0d required=3", k);
        end
        @(posedge clk); #1;
        m1_we = 1'b0; m1_wdata = '0;
        sb.push_back('{1'b1, 1'b0, 32'h12345678});
        wait_ack(10, k, seen);
        checks++;
        if (!seen || k != 3) begin
            errors++;
            $display("FAIL readback_ack_cycle actual=%0d required=3", k);
        end
        @(posedge clk); #1 m1_req = 1'b0;
    endtask

    task automatic test_contention();
        int idx = 0;
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{1'b0, 1'b0, 32'hA0A00200});
        sb.push_back('{1'b1, 1'b0, 32'hB1B10300});
        sb.push_back('{1'b0, 1'b0, 32'hA0A00200});
        sb.push_back('{1'b1, 1'b0, 32'hB1B10300});
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h200;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h300;
        for (int k = 0; k < 24 && idx < 4; k++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                checks++;
                if (k != 3 + 4 * idx || m1_ack !== idx[0]) begin
                    errors++;
                    $display("FAIL contention_grant idx=%0d cycle=%0d m1_ack=%b required cycle=%0d m1_ack=%b",
                             idx, k, m1_ack, 3 + 4 * idx, idx[0]);
                end
                idx++;
            end
        end
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL contention_count actual=%0d required=4", idx);
        end
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_misaligned();
        sb.push_back('{1'b1, 1'b1, 32'h0});
        @(posedge clk); #1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h102;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (mem_cs !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_cs cycle=%0d actual=%b required=0", k, mem_cs);
            end
            checks++;
            if (m1_ack !== (k == 1)) begin
                errors++;
                $display("FAIL misaligned_ack cycle=%0d actual=%b required=%b", k, m1_ack, k == 1);
            end
            if (k == 1) begin
                @(posedge clk); #1 m1_req = 1'b0;
            end
        end
    endtask

    task automatic test_timeout();
        rdy_en = 1'b0;
        sb.push_back('{1'b0, 1'b1, 32'h0});
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== (k >= 1 && k <= 17)) begin
                errors++;
                $display("FAIL timeout_busy cycle=%0d actual=%b required=%b", k, busy, k >= 1 && k <= 17);
            end
            checks++;
            if (m0_ack !== (k == 17)) begin
                errors++;
                $display("FAIL timeout_ack cycle=%0d actual=%b required=%b", k, m0_ack, k == 17);
            end
            if (k == 17) begin
                @(posedge clk); #1 m0_req = 1'b0;
            end
        end
        rdy_en = 1'b1;
    endtask

    task automatic test_reset_abort();
        int k;
        int acks = 0;
        bit seen;
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0; m0_req = 1'b0;
        #1;
        checks++;
        if ({mem_cs, mem_we, busy, m0_ack, m1_ack, m0_err, m1_err, mem_addr, mem_wdata, m0_rdata, m1_rdata} !== '0) begin
            errors++;
            $display("FAIL abort_outputs cs=%b busy=%b addr=%h ack0=%b required all 0", mem_cs, busy, mem_addr, m0_ack);
        end
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL abort_no_ack actual=%0d required=0", acks);
        end
        sb.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
        @(posedge clk); #1 m0_req = 1'b1;
        wait_ack(10, k, seen);
        checks++;
        if (!seen || k != 3) begin
            errors++;
            $display("FAIL abort_recover_cycle actual=%0d required=3", k);
        end
        @(posedge clk); #1 m0_req = 1'b0;
    endtask

    initial begin
        sram[8'h40] <= 32'hDEADBEEF;
        sram[8'h80] <= 32'hA0A00200;
        sram[8'hC0] <= 32'hB1B10300;
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_misaligned();
        test_timeout();
        test_reset_abort();
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
